// File: rtl/seq_shift_sub_divider.sv
// seq_shift_sub_divider: restoring divider retiring one quotient bit per clock
// Ports: clk, rst_n (async active-low); start/dividend/divisor request side;
//        busy, done (one-cycle pulse), quotient, remainder, div_by_zero results.
// Optional: define SEQ_DIV_SIGNED_EN for two's-complement operands.
module seq_shift_sub_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] a_mag, b_mag, rem_mag, quo_res, rem_res;
    logic             zero_div;
`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
`endif
    always_comb begin
        shifted  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial    = shifted - {1'b0, d_q};
        zero_div = d_q == '0;
        // with a zero divisor no steps run, so Q still holds the dividend magnitude
        rem_mag  = zero_div ? q_q : r_q[WIDTH-1:0];
`ifdef SEQ_DIV_SIGNED_EN
        a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag    = divisor[WIDTH-1] ? -divisor : divisor;
        quo_res  = zero_div ? '1 : (neg_q_q ? -q_q : q_q);
        rem_res  = neg_r_q ? -rem_mag : rem_mag;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
`else
        a_mag    = dividend;
        b_mag    = divisor;
        quo_res  = zero_div ? '1 : q_q;
        rem_res  = rem_mag;
`endif
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: if (start) begin
                q_d     = a_mag;
                d_d     = b_mag;
                r_d     = '0;
                // a zero divisor skips the steps and finalises on the next edge
                cnt_d   = (b_mag == '0) ? '0 : CNT_W'(WIDTH);
                state_d = S_RUN;
`ifdef SEQ_DIV_SIGNED_EN
                neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                neg_r_d = dividend[WIDTH-1];
`endif
            end
            S_RUN: if (cnt_q == '0) begin
                state_d = S_DONE;
                quo_d   = quo_res;
                rem_d   = rem_res;
                dbz_d   = zero_div;
            end else begin
                r_d   = trial[WIDTH] ? shifted : trial;
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end
    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_DONE;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_shift_sub_divider.sv
// tb_seq_shift_sub_divider: directed and random checks of seq_shift_sub_divider against a reference model
module tb_seq_shift_sub_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int          n_checks = 0;
    int          n_errors = 0;
    seq_shift_sub_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        z = (b == 32'd0);
        if (z) begin
            q = '1;
            r = a;
        end
`ifdef SEQ_DIV_SIGNED_EN
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endtask
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done && lat < 200);
        check("done_seen", done, 1);
    endtask
    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        int          lat;
        ref_div(a, b, eq, er, ez);
        start_op(a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done(lat);
        check({tag, "_lat"}, lat, ez ? 1 : 33);
        check({tag, "_quo"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
    endtask
    initial begin
        int lat, ndone;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quo", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        run_check("d100_7", 32'd100, 32'd7);
        check("d100_7_q14", quotient, 14);
        check("d100_7_r2", remainder, 2);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        start_op(32'hFFFF_FFFF, 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        dividend = 32'd5;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 27);
        check("ign_quo", quotient, 32'hFFFF_FFFF);
        check("ign_rem", remainder, 0);
        run_check("d5_5", 32'd5, 32'd5);
        check("d5_5_q1", quotient, 1);
        run_check("dz1234", 32'd1234, 32'd0);
        check("dz1234_q", quotient, 32'hFFFF_FFFF);
        check("dz1234_r", remainder, 1234);
        run_check("d9_10", 32'd9, 32'd10);
        check("d9_10_r", remainder, 9);
        run_check("d0_3", 32'd0, 32'd3);
        start_op(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_quo", quotient, 0);
        check("arst_rem", remainder, 0);
        check("arst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        check("arst_nodone", ndone, 0);
        run_check("d1000_3", 32'd1000, 32'd3);
        check("d1000_3_q", quotient, 333);
        check("d1000_3_r", remainder, 1);
`ifdef SEQ_DIV_SIGNED_EN
        run_check("s_m7_2", 32'hFFFF_FFF9, 32'd2);
        check("s_m7_2_q", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_r", remainder, 32'hFFFF_FFFF);
        run_check("s_7_m2", 32'd7, 32'hFFFF_FFFE);
        check("s_7_m2_q", quotient, 32'hFFFF_FFFD);
        check("s_7_m2_r", remainder, 1);
        run_check("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        check("s_min_m1_q", quotient, 32'h8000_0000);
        run_check("s_dz_neg", 32'hFFFF_FF00, 32'd0);
`endif
        @(negedge clk);
        dividend = 32'd20;
        divisor  = 32'd6;
        start    = 1'b1;
        wait_done(lat);
        check("b2b_q1", quotient, 3);
        check("b2b_r1", remainder, 2);
        wait_done(lat);
        start = 1'b0;
        check("b2b_q2", quotient, 3);
        check("b2b_r2", remainder, 2);
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 16);
                3:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                4:       b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'd0;
            run_check("rnd", a, b);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
